// File: rtl/v_state_table_if.sv
// State table bus: query-pipe read port, update-pipe write port and status.
// The master side is the client that drives the pipes; the slave side is the table.
interface v_state_table_if #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned STATE_W = 104
);
    logic               i_state_ren;
    logic [ADDR_W-1:0]  i_state_raddr;
    logic [STATE_W-1:0] o_state_rdata;
    logic               i_upd_vld;
    logic [ADDR_W-1:0]  i_upd_addr;
    logic [STATE_W-1:0] i_upd_wdata;
    logic               o_upd_ack;
    logic               o_init_done;
    logic [15:0]        o_rd_cnt;

    modport master (
        output i_state_ren, i_state_raddr, i_upd_vld, i_upd_addr, i_upd_wdata,
        input  o_state_rdata, o_upd_ack, o_init_done, o_rd_cnt
    );

    modport slave (
        input  i_state_ren, i_state_raddr, i_upd_vld, i_upd_addr, i_upd_wdata,
        output o_state_rdata, o_upd_ack, o_init_done, o_rd_cnt
    );
endinterface

// File: rtl/v_state_table.sv
// Per-list state store. A flop array with one read port (1-cycle registered data)
// and one write port. After reset a sweep zeroes every entry before traffic is admitted;
// a read and a write to the same entry in the same cycle return the new data.
module v_state_table #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned STATE_W = 104
) (
    input  logic             clk,
    input  logic             rst,
    v_state_table_if.slave   bus
);
    typedef enum logic {StInit, StReady} state_e;

    state_e             state_q;
    logic [ADDR_W-1:0]  init_ptr_q;
    logic [STATE_W-1:0] rdata_q;
    logic               init_done_q;
    logic [15:0]        rd_cnt_q;
    logic [STATE_W-1:0] mem_q [2**ADDR_W];

    logic upd_ack;
    logic bypass;

    // Updates are only accepted once the sweep has finished.
    always_comb begin
        upd_ack = bus.i_upd_vld && (state_q == StReady);
        bypass  = upd_ack && (bus.i_upd_addr == bus.i_state_raddr);
    end

    // Control FSM with registered read data, init flag and saturating read counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StInit;
            init_ptr_q  <= '0;
            rdata_q     <= '0;
            init_done_q <= 1'b0;
            rd_cnt_q    <= '0;
        end else begin
            unique case (state_q)
                StInit: begin
                    init_ptr_q <= init_ptr_q + 1'b1;
                    if (init_ptr_q == '1) begin
                        state_q     <= StReady;
                        init_done_q <= 1'b1;
                    end
                end
                StReady: begin
                    if (bus.i_state_ren) begin
                        // Write-first: a same-cycle update to the read entry wins.
                        rdata_q <= bypass ? bus.i_upd_wdata : mem_q[bus.i_state_raddr];
                        if (rd_cnt_q != 16'hFFFF) begin
                            rd_cnt_q <= rd_cnt_q + 16'd1;
                        end
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

    // Array write port: sweep clears entries, otherwise accepted updates land.
    always_ff @(posedge clk) begin
        if (state_q == StInit) begin
            mem_q[init_ptr_q] <= '0;
        end else if (upd_ack) begin
            mem_q[bus.i_upd_addr] <= bus.i_upd_wdata;
        end
    end

    // Drive the bus outputs.
    always_comb begin
        bus.o_state_rdata = rdata_q;
        bus.o_upd_ack     = upd_ack;
        bus.o_init_done   = init_done_q;
        bus.o_rd_cnt      = rd_cnt_q;
    end
endmodule

// File: tb/tb_v_state_table.sv
// Directed bench for v_state_table: reset, init sweep, reads/updates, bypass,
// mid-sweep reset and read-counter saturation.
module tb_v_state_table;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned STATE_W = 104;
    localparam int unsigned DEPTH   = 2**ADDR_W;

    logic clk;
    logic rst;

    int errors;
    int checks;
    int exp_cnt;

    logic [STATE_W-1:0] w_a5;
    logic [STATE_W-1:0] w_5a;
    logic [STATE_W-1:0] w_old;
    logic [STATE_W-1:0] w_c3;
    logic [STATE_W-1:0] w_drop;

    v_state_table_if #(.ADDR_W(ADDR_W), .STATE_W(STATE_W)) bus ();

    v_state_table #(.ADDR_W(ADDR_W), .STATE_W(STATE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_state_ren   = 1'b0;
        bus.i_state_raddr = '0;
        bus.i_upd_vld     = 1'b0;
        bus.i_upd_addr    = '0;
        bus.i_upd_wdata   = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        step();
        step();
        checks++;
        if (bus.o_state_rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata: got %h want 0", bus.o_state_rdata);
        end
        checks++;
        if (bus.o_init_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_init_done: got %b want 0", bus.o_init_done);
        end
        checks++;
        if (bus.o_rd_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rd_cnt: got %h want 0000", bus.o_rd_cnt);
        end
        exp_cnt = 0;
    endtask

    // Release reset and run the sweep; an update and a read at sweep cycle 10 are ignored.
    task automatic test_init_sweep();
        int bad_low;
        bad_low = 0;
        rst = 1'b1;
        for (int c = 0; c < int'(DEPTH); c++) begin
            if (c == 10) begin
                bus.i_upd_vld     = 1'b1;
                bus.i_upd_addr    = 8'h44;
                bus.i_upd_wdata   = w_drop;
                bus.i_state_ren   = 1'b1;
                bus.i_state_raddr = 8'h44;
                #1;
                checks++;
                if (bus.o_upd_ack !== 1'b0) begin
                    errors++;
                    $display("FAIL init_upd_ack: got %b want 0", bus.o_upd_ack);
                end
            end else begin
                idle_inputs();
            end
            if (bus.o_init_done !== 1'b0) bad_low++;
            step();
        end
        idle_inputs();
        checks++;
        if (bad_low != 0) begin
            errors++;
            $display("FAIL sweep_init_done_low: got %0d high cycles want 0", bad_low);
        end
        checks++;
        if (bus.o_init_done !== 1'b1) begin
            errors++;
            $display("FAIL sweep_init_done_rise: got %b want 1", bus.o_init_done);
        end
        checks++;
        if (bus.o_rd_cnt !== 16'h0000 || bus.o_state_rdata !== '0) begin
            errors++;
            $display("FAIL init_read_ignored: got cnt=%h rdata=%h want 0/0",
                     bus.o_rd_cnt, bus.o_state_rdata);
        end
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] addr);
        bus.i_state_ren   = 1'b1;
        bus.i_state_raddr = addr;
        step();
        bus.i_state_ren   = 1'b0;
        exp_cnt++;
    endtask

    task automatic test_init_reads();
        logic [ADDR_W-1:0] addrs [4];
        addrs[0] = 8'h00;
        addrs[1] = 8'h7F;
        addrs[2] = 8'hFF;
        addrs[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            bus.i_state_ren = 1'b1;
            bus.i_state_raddr = 8'h55;
            bus.i_upd_vld = 1'b0;
            do_read(addrs[i]);
            checks++;
            if (bus.o_state_rdata !== '0) begin
                errors++;
                $display("FAIL cleared_read[%h]: got %h want 0", addrs[i], bus.o_state_rdata);
            end
        end
        checks++;
        if (bus.o_rd_cnt !== exp_cnt[15:0]) begin
            errors++;
            $display("FAIL rd_cnt_after_reads: got %h want %h", bus.o_rd_cnt, exp_cnt[15:0]);
        end
    endtask

    task automatic test_write_read();
        bus.i_upd_vld   = 1'b0;
        #1;
        checks++;
        if (bus.o_upd_ack !== 1'b0) begin
            errors++;
            $display("FAIL ack_without_vld: got %b want 0", bus.o_upd_ack);
        end
        bus.i_upd_vld   = 1'b1;
        bus.i_upd_addr  = 8'h12;
        bus.i_upd_wdata = w_a5;
        #1;
        checks++;
        if (bus.o_upd_ack !== 1'b1) begin
            errors++;
            $display("FAIL ready_upd_ack: got %b want 1", bus.o_upd_ack);
        end
        step();
        bus.i_upd_vld = 1'b0;
        do_read(8'h12);
        checks++;
        if (bus.o_state_rdata !== w_a5) begin
            errors++;
            $display("FAIL write_then_read: got %h want %h", bus.o_state_rdata, w_a5);
        end
        step();
        step();
        step();
        checks++;
        if (bus.o_state_rdata !== w_a5) begin
            errors++;
            $display("FAIL rdata_hold: got %h want %h", bus.o_state_rdata, w_a5);
        end
    endtask

    task automatic test_bypass();
        bus.i_upd_vld   = 1'b1;
        bus.i_upd_addr  = 8'h33;
        bus.i_upd_wdata = w_old;
        step();
        bus.i_upd_wdata = w_5a;
        do_read(8'h33);
        bus.i_upd_vld = 1'b0;
        checks++;
        if (bus.o_state_rdata !== w_5a) begin
            errors++;
            $display("FAIL bypass_same_addr: got %h want %h", bus.o_state_rdata, w_5a);
        end
        do_read(8'h33);
        checks++;
        if (bus.o_state_rdata !== w_5a) begin
            errors++;
            $display("FAIL bypass_stored: got %h want %h", bus.o_state_rdata, w_5a);
        end
    endtask

    task automatic test_diff_addr();
        bus.i_upd_vld   = 1'b1;
        bus.i_upd_addr  = 8'h40;
        bus.i_upd_wdata = w_c3;
        do_read(8'h12);
        bus.i_upd_vld = 1'b0;
        checks++;
        if (bus.o_state_rdata !== w_a5) begin
            errors++;
            $display("FAIL diff_addr_read: got %h want %h", bus.o_state_rdata, w_a5);
        end
        do_read(8'h40);
        checks++;
        if (bus.o_state_rdata !== w_c3) begin
            errors++;
            $display("FAIL diff_addr_write: got %h want %h", bus.o_state_rdata, w_c3);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int bad_low;
        bad_low = 0;
        idle_inputs();
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (bus.o_init_done !== 1'b0) bad_low++;
            step();
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        exp_cnt = 0;
        checks++;
        if (bus.o_rd_cnt !== 16'h0000 || bus.o_init_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_sweep_reset: got cnt=%h done=%b want 0000/0",
                     bus.o_rd_cnt, bus.o_init_done);
        end
        for (int c = 0; c < int'(DEPTH); c++) begin
            if (bus.o_init_done !== 1'b0) bad_low++;
            step();
        end
        checks++;
        if (bad_low != 0) begin
            errors++;
            $display("FAIL restart_init_done_low: got %0d high cycles want 0", bad_low);
        end
        checks++;
        if (bus.o_init_done !== 1'b1) begin
            errors++;
            $display("FAIL restart_init_done_rise: got %b want 1", bus.o_init_done);
        end
        do_read(8'h12);
        checks++;
        if (bus.o_state_rdata !== '0 || bus.o_rd_cnt !== 16'h0001) begin
            errors++;
            $display("FAIL restart_cleared: got rdata=%h cnt=%h want 0/0001",
                     bus.o_state_rdata, bus.o_rd_cnt);
        end
    endtask

    task automatic test_counter();
        int n;
        n = 16'hFFFE - exp_cnt;
        bus.i_state_ren = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.i_state_raddr = i[ADDR_W-1:0];
            step();
        end
        exp_cnt = exp_cnt + n;
        checks++;
        if (bus.o_rd_cnt !== 16'hFFFE) begin
            errors++;
            $display("FAIL cnt_before_sat: got %h want fffe", bus.o_rd_cnt);
        end
        step();
        checks++;
        if (bus.o_rd_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_reach_sat: got %h want ffff", bus.o_rd_cnt);
        end
        for (int i = 0; i < 5; i++) step();
        bus.i_state_ren = 1'b0;
        checks++;
        if (bus.o_rd_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_stay_sat: got %h want ffff", bus.o_rd_cnt);
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        exp_cnt = 0;
        w_a5    = {13{8'hA5}};
        w_5a    = {13{8'h5A}};
        w_old   = {13{8'h0F}};
        w_c3    = {13{8'hC3}};
        w_drop  = {13{8'hEE}};
        rst     = 1'b0;
        idle_inputs();

        test_reset();
        test_init_sweep();
        test_init_reads();
        test_write_read();
        test_bypass();
        test_diff_addr();
        test_reset_mid_sweep();
        test_counter();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
